// File: rtl/stopwatch_pkg.sv
// Shared types and elaboration-time helpers for the stopwatch control slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        longint span;
        result = 0;
        span   = 1;
        while (span < longint'(value)) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Mod-DIV prescaler: advances while run is high and emits a registered
// one-cycle tick on the cycle after the count wraps from DIV-1.
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int W = clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    // clr dominates run; with neither asserted the partial period is retained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (run) begin
                if (count == LAST) begin
                    count <= '0;
                    tick  <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch control sequencer: button edge detection, IDLE/RUN/LAP/STOP state
// machine and registered control pulses for the counter and display path.
module stopwatch_ctrl_fsm
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss_btn,
    input  logic       lap_btn,
    input  logic       cnt_max,
    output logic       cnt_tick,
    output logic       cnt_clr,
    output logic       lap_latch,
    output logic       disp_hold,
    output logic [1:0] state_o
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);

    state_t state;
    state_t state_next;
    logic   ss_q;
    logic   lap_q;
    logic   ss_press;
    logic   lap_press;
    logic   clr_next;
    logic   latch_next;
    logic   running_now;
    logic   running_next;
    logic   run_en;
    logic   prescale_clr;

    // Presses are registered, so a press seen at one edge acts at the next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q      <= 1'b0;
            lap_q     <= 1'b0;
            ss_press  <= 1'b0;
            lap_press <= 1'b0;
            state     <= IDLE;
            cnt_clr   <= 1'b0;
            lap_latch <= 1'b0;
            disp_hold <= 1'b0;
        end else begin
            ss_q      <= ss_btn;
            lap_q     <= lap_btn;
            ss_press  <= ss_btn & ~ss_q;
            lap_press <= lap_btn & ~lap_q;
            state     <= state_next;
            cnt_clr   <= clr_next;
            lap_latch <= latch_next;
            disp_hold <= (state_next == LAP);
        end
    end

    // ss outranks lap everywhere; a saturated counter blocks restart from STOP
    always_comb begin
        state_next = state;
        clr_next   = 1'b0;
        latch_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_press) begin
                    state_next = RUN;
                end else if (lap_press) begin
                    clr_next = 1'b1;
                end
            end
            RUN: begin
                if (ss_press || cnt_max) begin
                    state_next = STOP;
                end else if (lap_press) begin
                    state_next = LAP;
                    latch_next = 1'b1;
                end
            end
            LAP: begin
                if (ss_press || cnt_max) begin
                    state_next = STOP;
                end else if (lap_press) begin
                    state_next = RUN;
                end
            end
            STOP: begin
                if (ss_press && !cnt_max) begin
                    state_next = RUN;
                end else if (lap_press) begin
                    state_next = IDLE;
                    clr_next   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The prescaler only advances on edges that stay inside RUN/LAP
    assign running_now  = (state == RUN) || (state == LAP);
    assign running_next = (state_next == RUN) || (state_next == LAP);
    assign run_en       = running_now && running_next && !cnt_max;
    assign prescale_clr = (state_next == IDLE);
    assign state_o      = state;

    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .run (run_en),
        .clr (prescale_clr),
        .tick(cnt_tick)
    );

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Self-checking bench for stopwatch_ctrl_fsm: directed scenarios plus random
// button traffic, all compared each cycle against a behavioural model.
module tb_stopwatch_ctrl_fsm;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_btn;
    logic       lap_btn;
    logic       cnt_max;
    logic       cnt_tick;
    logic       cnt_clr;
    logic       lap_latch;
    logic       disp_hold;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;

    int         tick_count;
    int         latch_count;
    int         clr_count;
    int         change_count;
    logic [1:0] prev_state;

    // Model: 0=idle 1=run 2=lap 3=stop, phase = running edges into current period
    int   m_state;
    int   m_phase;
    logic m_ss_prev;
    logic m_lap_prev;
    logic m_ss_pend;
    logic m_lap_pend;
    logic m_tick;
    logic m_clr;
    logic m_latch;

    always #5 clk = ~clk;

    stopwatch_ctrl_fsm #(
        .CLK_HZ (10),
        .TICK_HZ(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_btn   (ss_btn),
        .lap_btn  (lap_btn),
        .cnt_max  (cnt_max),
        .cnt_tick (cnt_tick),
        .cnt_clr  (cnt_clr),
        .lap_latch(lap_latch),
        .disp_hold(disp_hold),
        .state_o  (state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_state    = 0;
        m_phase    = 0;
        m_ss_prev  = 1'b0;
        m_lap_prev = 1'b0;
        m_ss_pend  = 1'b0;
        m_lap_pend = 1'b0;
        m_tick     = 1'b0;
        m_clr      = 1'b0;
        m_latch    = 1'b0;
    endtask

    // Predicts what the coming clock edge produces from the current inputs
    task automatic modelStep();
        int   nxt;
        logic running;
        if (rst) begin
            modelReset();
            return;
        end
        nxt     = m_state;
        m_clr   = 1'b0;
        m_latch = 1'b0;
        m_tick  = 1'b0;
        running = (m_state == 1) || (m_state == 2);
        if (m_ss_pend && !(m_state == 3 && cnt_max)) begin
            nxt = (m_state == 1 || m_state == 2) ? 3 : 1;
        end else if (running && cnt_max) begin
            nxt = 3;
        end else if (m_lap_pend) begin
            case (m_state)
                0, 3: begin nxt = 0; m_clr = 1'b1; end
                1:    begin nxt = 2; m_latch = 1'b1; end
                default: nxt = 1;
            endcase
        end
        if (nxt == 0) begin
            m_phase = 0;
        end else if (running && (nxt == 1 || nxt == 2) && !cnt_max) begin
            m_phase = m_phase + 1;
            if (m_phase == DIV) begin
                m_phase = 0;
                m_tick  = 1'b1;
            end
        end
        m_ss_pend  = ss_btn & ~m_ss_prev;
        m_lap_pend = lap_btn & ~m_lap_prev;
        m_ss_prev  = ss_btn;
        m_lap_prev = lap_btn;
        m_state    = nxt;
    endtask

    task automatic checkOutput();
        check("cnt_tick", 32'(cnt_tick), 32'(m_tick));
        check("cnt_clr", 32'(cnt_clr), 32'(m_clr));
        check("lap_latch", 32'(lap_latch), 32'(m_latch));
        check("disp_hold", 32'(disp_hold), 32'(m_state == 2));
        check("state_o", 32'(state_o), 32'(m_state));
    endtask

    task automatic clearCounters();
        tick_count   = 0;
        latch_count  = 0;
        clr_count    = 0;
        change_count = 0;
        prev_state   = state_o;
    endtask

    task automatic applyStimulus(input logic ss, input logic lap, input logic mx);
        ss_btn  = ss;
        lap_btn = lap;
        cnt_max = mx;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
        if (cnt_tick === 1'b1) tick_count++;
        if (lap_latch === 1'b1) latch_count++;
        if (cnt_clr === 1'b1) clr_count++;
        if (state_o !== prev_state) change_count++;
        prev_state = state_o;
    endtask

    // Steps with no buttons until a tick appears; returns -1 if none in 20 cycles
    task automatic stepsToTick(output int gap);
        gap = -1;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (cnt_tick === 1'b1) begin
                gap = i;
                break;
            end
        end
    endtask

    initial begin
        int   gap;
        logic r_ss;
        logic r_lap;
        logic r_mx;

        rst     = 1'b1;
        ss_btn  = 1'b0;
        lap_btn = 1'b0;
        cnt_max = 1'b0;
        modelReset();
        @(negedge clk);
        clearCounters();

        // Reset and idle
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        clearCounters();
        repeat (50) applyStimulus(1'b0, 1'b0, 1'b0);
        check("idle_ticks", 32'(tick_count), 32'd0);
        check("idle_state", 32'(state_o), 32'd0);

        // Run, stop after 35 running edges, resume with partial period
        clearCounters();
        repeat (30) applyStimulus(1'b1, 1'b0, 1'b0);
        check("run_state", 32'(state_o), 32'd1);
        check("run_ticks30", 32'(tick_count), 32'd2);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
        check("stop_state", 32'(state_o), 32'd3);
        check("run_ticks_total", 32'(tick_count), 32'd3);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        check("resume_state", 32'(state_o), 32'd1);
        stepsToTick(gap);
        check("resume_gap", 32'(gap), 32'd5);

        // Lap freeze and release
        clearCounters();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (13) applyStimulus(1'b0, 1'b0, 1'b0);
        check("lap_latches", 32'(latch_count), 32'd1);
        check("lap_hold", 32'(disp_hold), 32'd1);
        check("lap_state", 32'(state_o), 32'd2);
        check("lap_ticks", 32'(tick_count), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        check("unlap_hold", 32'(disp_hold), 32'd0);
        check("unlap_state", 32'(state_o), 32'd1);

        // Stop then clear, then a full first period
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        clearCounters();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        check("clr_pulses", 32'(clr_count), 32'd1);
        check("clr_state", 32'(state_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepsToTick(gap);
        check("fresh_gap", 32'(gap), 32'd10);

        // Simultaneous presses, then a long hold
        clearCounters();
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        check("simul_state", 32'(state_o), 32'd3);
        check("simul_latches", 32'(latch_count), 32'd0);
        clearCounters();
        repeat (100) applyStimulus(1'b1, 1'b0, 1'b0);
        check("held_changes", 32'(change_count), 32'd1);
        check("held_state", 32'(state_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Terminal count in LAP, ss ignored while saturated
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        check("lap2_state", 32'(state_o), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        clearCounters();
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (12) applyStimulus(1'b0, 1'b0, 1'b1);
        check("max_state", 32'(state_o), 32'd3);
        check("max_hold", 32'(disp_hold), 32'd0);
        check("max_ticks", 32'(tick_count), 32'd0);

        // Async reset while running
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (7) applyStimulus(1'b0, 1'b0, 1'b0);
        check("pre_rst_state", 32'(state_o), 32'd1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        check("arst_state", 32'(state_o), 32'd0);
        check("arst_tick", 32'(cnt_tick), 32'd0);
        check("arst_clr", 32'(cnt_clr), 32'd0);
        check("arst_latch", 32'(lap_latch), 32'd0);
        check("arst_hold", 32'(disp_hold), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random button traffic against the model
        r_ss  = 1'b0;
        r_lap = 1'b0;
        r_mx  = 1'b0;
        repeat (800) begin
            if ($urandom_range(0, 7) == 0) r_ss = ~r_ss;
            if ($urandom_range(0, 7) == 0) r_lap = ~r_lap;
            if ($urandom_range(0, 59) == 0) r_mx = ~r_mx;
            applyStimulus(r_ss, r_lap, r_mx);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
